// File: rtl/ap_host_pkg.sv
// Shared types and constants for the AP host controller.
package ap_host_pkg;

    localparam int unsigned AP_ADDR_W = 10;
    localparam int unsigned AP_DATA_W = 8;
    localparam int unsigned AP_CMD_W  = 3;
    localparam int unsigned ROW_W     = AP_ADDR_W + 1;

    localparam logic COL_A = 1'b0;
    localparam logic COL_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT_IRQ,
        READ,
        DONE
    } state_t;

    // A num_rows field of zero encodes a full 1024-row job.
    function automatic logic [ROW_W-1:0] job_rows(input logic [AP_ADDR_W-1:0] n);
        return (n == '0) ? {1'b1, {AP_ADDR_W{1'b0}}} : {1'b0, n};
    endfunction

endpackage

// File: rtl/ap_host_rd_buf.sv
// Two-entry valid/ready buffer holding AP read results until the host accepts them.
module ap_host_rd_buf
    import ap_host_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [AP_DATA_W-1:0] push_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [AP_DATA_W-1:0] out_data,
    output logic [1:0]           free
);

    logic [AP_DATA_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 pop;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign free      = 2'd2 - count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ap_host_ctrl.sv
// Host-side sequencer for an associative-processor array: load operands, run, wait, read back.
// Optional WAIT_IRQ watchdog enabled by defining AP_HOST_TIMEOUT_EN.
module ap_host_ctrl
    import ap_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AP_CMD_W-1:0]  op,
    input  logic [AP_ADDR_W-1:0] num_rows,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AP_DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AP_DATA_W-1:0] out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 ap_mode,
    output logic [AP_CMD_W-1:0]  ap_cmd,
    output logic                 ap_sel_col,
    output logic                 ap_write_en,
    output logic [AP_DATA_W-1:0] ap_data,
    output logic [AP_ADDR_W-1:0] ap_addr,
    input  logic [AP_DATA_W-1:0] ap_data_out,
    input  logic                 ap_state_irq
);

    state_t              state;
    state_t              state_nxt;
    logic [ROW_W-1:0]    row;
    logic [ROW_W-1:0]    rows_q;
    logic [AP_CMD_W-1:0] op_q;
    logic                beat_odd;
    logic                pending;
    logic                irq_prev;
    logic                beat;
    logic                last_beat;
    logic                irq_rise;
    logic                issue;
    logic                rd_last;
    logic                timeout;
    logic [1:0]          buf_free;

    assign beat      = (state == LOAD) && in_valid;
    assign last_beat = beat && beat_odd && ((row + ROW_W'(1)) == rows_q);
    assign irq_rise  = ap_state_irq && !irq_prev;
    // Reads are strictly serialised: a new one issues only with nothing in flight and a free slot.
    assign issue     = (state == READ) && !pending && (row != rows_q) && (buf_free != 2'd0);
    assign rd_last   = (row == rows_q) && !pending &&
                       ((buf_free == 2'd2) || ((buf_free == 2'd1) && out_ready));

`ifdef AP_HOST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign timeout = (state == WAIT_IRQ) && !irq_rise &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_IRQ) ? tmo_cnt + TMO_W'(1) : '0;
            if ((state == IDLE) && start) err_q <= 1'b0;
            else if (timeout)             err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = LOAD;
            LOAD:     if (last_beat) state_nxt = RUN;
            RUN:      state_nxt = WAIT_IRQ;
            WAIT_IRQ: begin
                if (irq_rise)     state_nxt = READ;
                else if (timeout) state_nxt = DONE;
            end
            READ:     if (rd_last) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            rows_q   <= '0;
            op_q     <= '0;
            beat_odd <= 1'b0;
            pending  <= 1'b0;
            irq_prev <= 1'b0;
        end else begin
            irq_prev <= ap_state_irq;
            pending  <= issue;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        rows_q   <= job_rows(num_rows);
                        row      <= '0;
                        beat_odd <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        beat_odd <= ~beat_odd;
                        if (beat_odd) row <= row + ROW_W'(1);
                    end
                end
                WAIT_IRQ: if (irq_rise) row <= '0;
                READ:     if (issue) row <= row + ROW_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state == LOAD);
        busy        = (state != IDLE);
        done        = (state == DONE);
        ap_mode     = (state == RUN) || (state == WAIT_IRQ);
        ap_cmd      = (state == RUN) ? op_q : '0;
        ap_write_en = beat;
        ap_data     = beat ? in_data : '0;
        ap_sel_col  = COL_A;
        if (state == READ)         ap_sel_col = COL_B;
        else if (beat && beat_odd) ap_sel_col = COL_B;
        // Address is driven only while it names a real row, so it never wraps past the job.
        ap_addr     = (beat || issue) ? row[AP_ADDR_W-1:0] : '0;
    end

    ap_host_rd_buf u_rd_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending),
        .push_data (ap_data_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .free      (buf_free)
    );

endmodule

// File: doc/ap_host_ctrl.md
AP_HOST_CTRL -- requirements
Module: ap_host_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 4096, WAIT_IRQ watchdog limit in clk cycles; used only with AP_HOST_TIMEOUT_EN.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  job request; sampled only in IDLE.
REQ-005 op  in  3  AP operation code; captured at start.
REQ-006 num_rows  in  10  rows in job; captured at start; 0 means 1024.
REQ-007 in_valid / in_ready / in_data  in / out / in  1/1/8  operand stream, order A0,B0,A1,B1,...
REQ-008 out_valid / out_ready / out_data  out / in / out  1/1/8  result stream, row 0 first.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  one-cycle pulse at job end.
REQ-011 err  out  1  status of the last job; valid from done until next start.
REQ-012 ap_mode, ap_cmd[2:0], ap_sel_col, ap_write_en, ap_data[7:0], ap_addr[9:0]  out  AP array drive.
REQ-013 ap_data_out[7:0], ap_state_irq  in  AP read data and completion flag.

Function
REQ-014 States SHALL be IDLE, LOAD, RUN, WAIT_IRQ, READ, DONE.
REQ-015 IDLE: start=1 captures op/num_rows, clears err and the row counter, and moves to LOAD. start in any other state is ignored.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready beat drives ap_write_en=1, ap_data=in_data, ap_addr=row, ap_sel_col=0 for even beats and 1 for odd beats, for exactly that cycle.
REQ-017 Row SHALL increment after each B beat; after the B beat of row num_rows-1, go to RUN. An in_valid=0 cycle is a stall with ap_write_en=0.
REQ-018 RUN: one cycle with ap_cmd=op, ap_mode=1; then WAIT_IRQ.
REQ-019 WAIT_IRQ: ap_mode SHALL be held at 1. A rising edge of ap_state_irq (registered 1-cycle detect) drops ap_mode to 0 the next cycle, resets row to 0, and moves to READ.
REQ-020 READ: ap_sel_col=1 and ap_write_en=0. The AP read latency is 1 cycle: the value on ap_data_out the cycle after ap_addr=row is row's result.
REQ-021 Only one read SHALL be in flight; read of row r+1 issues only when the output buffer has a free entry. No result is dropped or duplicated under any out_ready pattern.
REQ-022 After the last result of num_rows is accepted on the out stream, go to DONE. DONE: done=1 for one cycle, then IDLE.
REQ-023 Row counter is 11 bits internally so that 1024 rows terminate. ap_addr SHALL be the low 10 bits and SHALL never wrap within a job.
REQ-024 In every state other than LOAD/READ, ap_write_en=0 and out_valid=0 (buffer empty). in_ready=0 outside LOAD.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, all ap_* outputs=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0, counters=0, output buffer emptied.
REQ-026 Reset mid-job SHALL abandon the job without a done pulse; ap_mode falls immediately.

Configuration
REQ-027 With AP_HOST_TIMEOUT_EN defined, a counter runs in WAIT_IRQ. If TIMEOUT_CYCLES elapse without irq, the block sets err=1, drops ap_mode, skips READ, and goes to DONE.
REQ-028 Without AP_HOST_TIMEOUT_EN, WAIT_IRQ waits indefinitely, err is tied to 0, and no timeout counter exists.

Structure
REQ-029 Package ap_host_pkg SHALL hold the state enum, AP_ADDR_W=10, AP_DATA_W=8, AP_CMD_W=3, and COL_A=0/COL_B=1 constants.
REQ-030 Sub-module ap_host_rd_buf: a 2-entry valid/ready output buffer accepting ap_data_out and reporting free entries.

Verification
REQ-031 num_rows=2, op=3, beats 0x11,0x22,0x33,0x44 -> writes (addr0,colA,0x11), (0,B,0x22), (1,A,0x33), (1,B,0x44), then one RUN cycle with ap_cmd=3, ap_mode=1.
REQ-032 irq asserted 20 cycles after RUN; AP returns 0x55, 0x77 -> ap_mode=0 next cycle, out stream 0x55, 0x77, done pulse, err=0.
REQ-033 out_ready toggling 1,0,0,1 during READ of 4 rows -> all 4 results emitted in order, no duplicates, and ap_addr never passes 3.
REQ-034 num_rows=0 -> 2048 write beats; last write at addr 1023; 1024 results read.
REQ-035 With AP_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16, and irq never asserted -> done and err=1 in the 17th cycle of WAIT_IRQ, with no out_valid.
REQ-036 rst_n low for 1 cycle during LOAD row 5 -> all outputs 0 immediately, no done pulse, and the next start runs a full job correctly.
